// File: rtl/id_ex_skid_reg.sv
// id_ex_skid_reg
//   Elastic ID/EX pipeline register. Carries the decoded control bundle and
//   operands from decode to execute through a two-entry skid buffer. Both
//   sides use valid/ready handshakes. in_ready is taken straight from a
//   register, so execute stalls never reach decode through a combinational
//   path. Empty slots drive all-zero outputs, so a bubble cannot write a
//   register or memory.
//
// Ports
//   clk, reset            rising-edge clock, asynchronous active-high reset
//   flush                 synchronous flush of held and incoming entries
//   in_valid / in_ready   decode-side handshake
//   in_ctrl .. in_funct   decode-side payload
//   out_valid / out_ready execute-side handshake
//   out_ctrl .. out_funct head-entry payload (zero when out_valid = 0)
//   occupancy             number of entries held (0..2)
module id_ex_skid_reg #(
  parameter int XLEN    = 64,
  parameter int RA_W    = 5,
  parameter int FUNCT_W = 4,
  parameter int CTRL_W  = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [CTRL_W-1:0]  in_ctrl,
  input  logic [XLEN-1:0]    in_pc,
  input  logic [XLEN-1:0]    in_rdata1,
  input  logic [XLEN-1:0]    in_rdata2,
  input  logic [XLEN-1:0]    in_imm,
  input  logic [RA_W-1:0]    in_rs1,
  input  logic [RA_W-1:0]    in_rs2,
  input  logic [RA_W-1:0]    in_rd,
  input  logic [FUNCT_W-1:0] in_funct,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [CTRL_W-1:0]  out_ctrl,
  output logic [XLEN-1:0]    out_pc,
  output logic [XLEN-1:0]    out_rdata1,
  output logic [XLEN-1:0]    out_rdata2,
  output logic [XLEN-1:0]    out_imm,
  output logic [RA_W-1:0]    out_rs1,
  output logic [RA_W-1:0]    out_rs2,
  output logic [RA_W-1:0]    out_rd,
  output logic [FUNCT_W-1:0] out_funct,
  output logic [1:0]         occupancy
);

  localparam int PAY_W = CTRL_W + 4 * XLEN + 3 * RA_W + FUNCT_W;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t             state;
  logic               vld_p0;   // skid entry valid
  logic               vld_p1;   // main (head) entry valid
  logic [PAY_W-1:0]   data_p0;  // skid entry payload
  logic [PAY_W-1:0]   data_p1;  // main entry payload
  logic [PAY_W-1:0]   in_pay;
  logic [PAY_W-1:0]   out_pay;
  logic [1:0]         occ_q;
  logic               accept;
  logic               pop;

  assign in_pay = {in_ctrl, in_pc, in_rdata1, in_rdata2, in_imm,
                   in_rs1, in_rs2, in_rd, in_funct};

  // in_ready depends only on the skid register, never on out_ready.
  assign in_ready  = ~vld_p0;
  assign accept    = in_valid & in_ready & ~flush;
  assign pop       = vld_p1 & out_ready;
  assign occupancy = occ_q;

  // ---- decode -> skid/main stage ----
  // Flush drops everything, including the entry offered this cycle. The
  // payload is left as is because the outputs are gated by the valid bit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= EMPTY;
      vld_p0  <= 1'b0;
      vld_p1  <= 1'b0;
      occ_q   <= 2'd0;
      data_p0 <= '0;
      data_p1 <= '0;
    end else if (flush) begin
      state  <= EMPTY;
      vld_p0 <= 1'b0;
      vld_p1 <= 1'b0;
      occ_q  <= 2'd0;
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            data_p1 <= in_pay;
            vld_p1  <= 1'b1;
            occ_q   <= 2'd1;
            state   <= ONE;
          end
        end
        ONE: begin
          if (accept && pop) begin
            data_p1 <= in_pay;
          end else if (accept) begin
            // Head is stalled: park the new entry in the skid slot.
            data_p0 <= in_pay;
            vld_p0  <= 1'b1;
            occ_q   <= 2'd2;
            state   <= FULL;
          end else if (pop) begin
            vld_p1 <= 1'b0;
            occ_q  <= 2'd0;
            state  <= EMPTY;
          end
        end
        FULL: begin
          // in_ready is low here, so only a pop can move the buffer.
          if (pop) begin
            data_p1 <= data_p0;
            vld_p0  <= 1'b0;
            occ_q   <= 2'd1;
            state   <= ONE;
          end
        end
        default: begin
          vld_p0 <= 1'b0;
          vld_p1 <= 1'b0;
          occ_q  <= 2'd0;
          state  <= EMPTY;
        end
      endcase
    end
  end

  // ---- main -> execute stage ----
  assign out_valid = vld_p1;
  assign out_pay   = vld_p1 ? data_p1 : '0;
  assign {out_ctrl, out_pc, out_rdata1, out_rdata2, out_imm,
          out_rs1, out_rs2, out_rd, out_funct} = out_pay;

endmodule

// File: tb/tb_id_ex_skid_reg.sv
// Testbench for id_ex_skid_reg: directed scenarios plus a randomised
// valid/ready run, with a queue scoreboard tracking the expected entries.
module tb_id_ex_skid_reg;

  localparam int XLEN    = 64;
  localparam int RA_W    = 5;
  localparam int FUNCT_W = 4;
  localparam int CTRL_W  = 8;
  localparam int PW      = CTRL_W + 4 * XLEN + 3 * RA_W + FUNCT_W;

  logic               clk = 1'b0;
  logic               reset;
  logic               flush;
  logic               in_valid;
  logic               in_ready;
  logic [CTRL_W-1:0]  in_ctrl;
  logic [XLEN-1:0]    in_pc, in_rdata1, in_rdata2, in_imm;
  logic [RA_W-1:0]    in_rs1, in_rs2, in_rd;
  logic [FUNCT_W-1:0] in_funct;
  logic               out_valid;
  logic               out_ready;
  logic [CTRL_W-1:0]  out_ctrl;
  logic [XLEN-1:0]    out_pc, out_rdata1, out_rdata2, out_imm;
  logic [RA_W-1:0]    out_rs1, out_rs2, out_rd;
  logic [FUNCT_W-1:0] out_funct;
  logic [1:0]         occupancy;

  int errors = 0;
  int checks = 0;
  logic [PW-1:0] sb_q[$];

  id_ex_skid_reg #(
    .XLEN(XLEN), .RA_W(RA_W), .FUNCT_W(FUNCT_W), .CTRL_W(CTRL_W)
  ) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_ctrl(in_ctrl), .in_pc(in_pc), .in_rdata1(in_rdata1),
    .in_rdata2(in_rdata2), .in_imm(in_imm), .in_rs1(in_rs1),
    .in_rs2(in_rs2), .in_rd(in_rd), .in_funct(in_funct),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_ctrl(out_ctrl), .out_pc(out_pc), .out_rdata1(out_rdata1),
    .out_rdata2(out_rdata2), .out_imm(out_imm), .out_rs1(out_rs1),
    .out_rs2(out_rs2), .out_rd(out_rd), .out_funct(out_funct),
    .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  function automatic logic [PW-1:0] in_all();
    return {in_ctrl, in_pc, in_rdata1, in_rdata2, in_imm,
            in_rs1, in_rs2, in_rd, in_funct};
  endfunction

  function automatic logic [PW-1:0] out_all();
    return {out_ctrl, out_pc, out_rdata1, out_rdata2, out_imm,
            out_rs1, out_rs2, out_rd, out_funct};
  endfunction

  task automatic check(input string tag, input logic [PW-1:0] obs,
                       input logic [PW-1:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Set inputs; payload fields are derived from pc so every entry is distinct.
  task automatic drive(input logic v, input logic [XLEN-1:0] pc,
                       input logic rdy, input logic fl);
    in_valid  = v;
    in_pc     = pc;
    in_ctrl   = pc[9:2];
    in_rdata1 = pc ^ 64'h1111_0000_0000_1111;
    in_rdata2 = ~pc;
    in_imm    = pc + 64'd77;
    in_rs1    = pc[6:2];
    in_rs2    = pc[7:3];
    in_rd     = pc[8:4];
    in_funct  = pc[5:2];
    out_ready = rdy;
    flush     = fl;
  endtask

  // Evaluate one cycle at the falling edge, then advance to just after the
  // next rising edge. The queue size is the expected occupancy.
  task automatic step(output logic accepted);
    logic acc, pp;
    logic [PW-1:0] exp;
    @(negedge clk);
    check("occ", PW'(occupancy), PW'(sb_q.size()));
    check("out_valid", PW'(out_valid), PW'(sb_q.size() != 0));
    check("in_ready", PW'(in_ready), PW'(sb_q.size() < 2));
    if (!out_valid) check("bubble_zero", out_all(), '0);
    acc = in_valid && (sb_q.size() < 2) && !flush;
    pp  = out_ready && (sb_q.size() != 0);
    if (pp) begin
      exp = sb_q.pop_front();
      check("out_entry", out_all(), exp);
    end
    if (flush) sb_q.delete();
    else if (acc) sb_q.push_back(in_all());
    accepted = acc;
    @(posedge clk);
    #1;
  endtask

  logic acc;
  logic got;

  initial begin
    drive(1'b0, 64'h0, 1'b0, 1'b0);
    reset = 1'b1;
    #12;
    check("rst_valid", PW'(out_valid), '0);
    check("rst_outs", out_all(), '0);
    check("rst_occ", PW'(occupancy), '0);
    check("rst_ready", PW'(in_ready), PW'(1));
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;

    // Streaming: one entry per cycle with execute always ready.
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 64'h1000 + 64'(4 * i), 1'b1, 1'b0);
      step(acc);
      check("stream_pc", PW'(out_pc), PW'(64'h1000 + 64'(4 * i)));
      check("stream_occ", PW'(occupancy), PW'(1));
      check("stream_ready", PW'(in_ready), PW'(1));
    end
    drive(1'b0, 64'h0, 1'b1, 1'b0);
    step(acc);

    // Backpressure: fill to FULL, third entry held off, then drain in order.
    drive(1'b1, 64'h2000, 1'b0, 1'b0);
    step(acc);
    check("bp_occ1", PW'(occupancy), PW'(1));
    drive(1'b1, 64'h2004, 1'b0, 1'b0);
    step(acc);
    check("bp_occ2", PW'(occupancy), PW'(2));
    check("bp_ready0", PW'(in_ready), '0);
    drive(1'b1, 64'h2008, 1'b0, 1'b0);
    step(acc);
    check("bp_held", PW'(acc), '0);
    got = 1'b0;
    for (int i = 0; i < 8 && !got; i++) begin
      drive(1'b1, 64'h2008, 1'b1, 1'b0);
      step(got);
    end
    check("bp_accept_2008", PW'(got), PW'(1));
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 64'h0, 1'b1, 1'b0);
      step(acc);
    end
    check("bp_drained", PW'(sb_q.size()), '0);

    // Flush while FULL of all-ones control entries.
    drive(1'b1, 64'h5000, 1'b0, 1'b0); in_ctrl = 8'hFF;
    step(acc);
    drive(1'b1, 64'h5004, 1'b0, 1'b0); in_ctrl = 8'hFF;
    step(acc);
    check("fl_full", PW'(occupancy), PW'(2));
    drive(1'b1, 64'h4000, 1'b0, 1'b1);
    step(acc);
    check("fl_valid", PW'(out_valid), '0);
    check("fl_ctrl", PW'(out_ctrl), '0);
    check("fl_occ", PW'(occupancy), '0);
    check("fl_ready", PW'(in_ready), PW'(1));
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 64'h0, 1'b1, 1'b0);
      step(acc);
    end

    // Idle after an entry with rd = 5 and imm = 0xDEAD: outputs stay zero.
    drive(1'b1, 64'h6000, 1'b1, 1'b0); in_rd = 5'd5; in_imm = 64'hDEAD;
    step(acc);
    check("idle_rd_live", PW'(out_rd), PW'(5));
    drive(1'b0, 64'h0, 1'b1, 1'b0);
    step(acc);
    step(acc);
    check("idle_valid", PW'(out_valid), '0);
    check("idle_ctrl", PW'(out_ctrl), '0);
    check("idle_rd", PW'(out_rd), '0);
    check("idle_imm", PW'(out_imm), '0);

    // Asynchronous reset between edges while FULL.
    drive(1'b1, 64'h7000, 1'b0, 1'b0);
    step(acc);
    drive(1'b1, 64'h7004, 1'b0, 1'b0);
    step(acc);
    check("ar_full", PW'(occupancy), PW'(2));
    drive(1'b0, 64'h0, 1'b0, 1'b0);
    #2 reset = 1'b1;
    #1;
    check("ar_valid", PW'(out_valid), '0);
    check("ar_occ", PW'(occupancy), '0);
    check("ar_outs", out_all(), '0);
    check("ar_ready", PW'(in_ready), PW'(1));
    #2 reset = 1'b0;
    sb_q.delete();
    @(posedge clk); #1;
    drive(1'b1, 64'h3000, 1'b1, 1'b0);
    step(acc);
    check("ar_first_valid", PW'(out_valid), PW'(1));
    check("ar_first_pc", PW'(out_pc), PW'(64'h3000));
    drive(1'b0, 64'h0, 1'b1, 1'b0);
    step(acc);

    // Randomised valid/ready, no flush.
    for (int i = 0; i < 10000; i++) begin
      drive(1'($urandom_range(0, 1)), {$urandom, $urandom},
            1'($urandom_range(0, 1)), 1'b0);
      in_ctrl = 8'($urandom);
      step(acc);
      check("rnd_ready_full", PW'(in_ready && occupancy == 2'd2), '0);
    end
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 64'h0, 1'b1, 1'b0);
      step(acc);
    end
    check("rnd_drained", PW'(sb_q.size()), '0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
